regfile_writeback: RTL and testbench

Write-back stage that owns the write port of the CPU's 32x32 register file. It merges single-cycle ALU results with multi-cycle memory-load results, buffers loads in a small FIFO when they collide with ALU writes, squashes stale loads overtaken by a newer ALU write to the same register, and drives registered `wb_we` / `wb_rd` / `wb_data` into the register file.

---
 rtl/regfile_writeback.sv | 140 ++++++++++++++
 tb/tb_regfile_writeback.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/regfile_writeback.sv
// regfile_writeback: owns the register-file write port.
// ALU results are written one edge after they arrive and always win the port.
// Load results queue in a small FIFO and drain when the ALU is idle. A newer
// ALU write to the same register clears the valid bit of older buffered loads,
// so a stale load can never overwrite a newer value.
// Optional feature macro: WB_LOAD_BYPASS_EN. When defined, a load arriving at
// an empty FIFO with no ALU traffic goes straight to wb_* on the same edge.
module regfile_writeback #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  alu_valid,
    input  logic [ADDR_W-1:0]                     alu_rd,
    input  logic [DATA_W-1:0]                     alu_data,
    input  logic                                  mem_valid,
    output logic                                  mem_ready,
    input  logic [ADDR_W-1:0]                     mem_rd,
    input  logic [DATA_W-1:0]                     mem_data,
    output logic                                  wb_we,
    output logic [ADDR_W-1:0]                     wb_rd,
    output logic [DATA_W-1:0]                     wb_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]       fifo_count
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    // Load buffer storage: valid bit may be cleared by a later ALU write.
    logic              valid_r [FIFO_DEPTH];
    logic [ADDR_W-1:0] rd_r    [FIFO_DEPTH];
    logic [DATA_W-1:0] data_r  [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [CNT_W-1:0]  count_r;

    logic              accept_s;
    logic              alu_wr_s;
    logic              bypass_s;
    logic              push_s;
    logic              push_valid_s;
    logic              pop_s;
    logic              wb_we_s;
    logic [ADDR_W-1:0] wb_rd_s;
    logic [DATA_W-1:0] wb_data_s;

    // Ready depends only on occupancy, never on mem_valid.
    assign mem_ready  = (count_r < CNT_W'(FIFO_DEPTH));
    assign fifo_count = count_r;

    assign accept_s = mem_valid && mem_ready;
    assign alu_wr_s = alu_valid && (alu_rd != {ADDR_W{1'b0}});

`ifdef WB_LOAD_BYPASS_EN
    assign bypass_s = accept_s && (mem_rd != {ADDR_W{1'b0}}) &&
                      (count_r == {CNT_W{1'b0}}) && !alu_valid;
`else
    assign bypass_s = 1'b0;
`endif

    // Loads to x0 complete the handshake but are dropped here.
    assign push_s       = accept_s && (mem_rd != {ADDR_W{1'b0}}) && !bypass_s;
    // A load colliding with a same-cycle ALU write to its register is older.
    assign push_valid_s = !(alu_valid && (alu_rd == mem_rd));
    // The FIFO only drains on cycles the ALU leaves the port free.
    assign pop_s        = !alu_valid && (count_r != {CNT_W{1'b0}});

    // Write-port arbitration: ALU first, then bypass, then FIFO head, else hold.
    always_comb begin
        wb_we_s   = 1'b0;
        wb_rd_s   = wb_rd;
        wb_data_s = wb_data;
        if (alu_valid) begin
            if (alu_rd != {ADDR_W{1'b0}}) begin
                wb_we_s   = 1'b1;
                wb_rd_s   = alu_rd;
                wb_data_s = alu_data;
            end else begin
                wb_we_s   = 1'b0;
            end
        end else if (bypass_s) begin
            wb_we_s   = 1'b1;
            wb_rd_s   = mem_rd;
            wb_data_s = mem_data;
        end else if (pop_s) begin
            wb_we_s   = valid_r[rd_ptr_r];
            wb_rd_s   = rd_r[rd_ptr_r];
            wb_data_s = data_r[rd_ptr_r];
        end else begin
            wb_we_s   = 1'b0;
        end
    end

    // Registered write-port outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_we   <= 1'b0;
            wb_rd   <= {ADDR_W{1'b0}};
            wb_data <= {DATA_W{1'b0}};
        end else begin
            wb_we   <= wb_we_s;
            wb_rd   <= wb_rd_s;
            wb_data <= wb_data_s;
        end
    end

    // FIFO state: squash matching entries, then push/pop and update occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                valid_r[i] <= 1'b0;
                rd_r[i]    <= {ADDR_W{1'b0}};
                data_r[i]  <= {DATA_W{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (alu_wr_s && (rd_r[i] == alu_rd)) begin
                    valid_r[i] <= 1'b0;
                end
            end
            // The push slot is never occupied, so it cannot clash with a squash.
            if (push_s) begin
                valid_r[wr_ptr_r] <= push_valid_s;
                rd_r[wr_ptr_r]    <= mem_rd;
                data_r[wr_ptr_r]  <= mem_data;
                wr_ptr_r          <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
        end
    end

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback with a write scoreboard: every expected
// register-file write is queued in output order and checked as wb_we fires.
module tb_regfile_writeback;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [4:0]  mem_rd;
    logic [31:0] mem_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [2:0]  fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [36:0] sb_q[$];

    regfile_writeback #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_data(mem_data),
        .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .fifo_count(fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
        alu_valid = av;  alu_rd = ard;  alu_data = adat;
        mem_valid = mv;  mem_rd = mrd;  mem_data = mdat;
    endtask

    task automatic expect_wr(input logic [4:0] rd, input logic [31:0] data);
        sb_q.push_back({rd, data});
    endtask

    // Scoreboard: each write-enable pulse must match the oldest expected write.
    always @(negedge clk) begin
        if (!rst && wb_we === 1'b1) begin
            n_checks++;
            assert (sb_q.size() > 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_write observed rd=%0d data=0x%08h expected no write",
                       wb_rd, wb_data);
            end
            if (sb_q.size() > 0) begin
                logic [36:0] e;
                e = sb_q.pop_front();
                check("sb_rd", {27'd0, wb_rd}, {27'd0, e[36:32]});
                check("sb_data", wb_data, e[31:0]);
            end
        end
    end

    initial begin
        rst = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        // Reset state
        check("rst_we", {31'd0, wb_we}, 32'd0);
        check("rst_rd", {27'd0, wb_rd}, 32'd0);
        check("rst_data", wb_data, 32'd0);
        check("rst_ready", {31'd0, mem_ready}, 32'd1);
        check("rst_count", {29'd0, fifo_count}, 32'd0);
        rst = 1'b0;
        tick();
        check("idle_we", {31'd0, wb_we}, 32'd0);
        check("idle_ready", {31'd0, mem_ready}, 32'd1);

        // ALU write to r5, then ALU to x0
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd5, 32'hDEADBEEF);
        tick();
        check("alu_we", {31'd0, wb_we}, 32'd1);
        check("alu_rd", {27'd0, wb_rd}, 32'd5);
        check("alu_data", wb_data, 32'hDEADBEEF);
        drive(1'b1, 5'd0, 32'h00000055, 1'b0, 5'd0, 32'd0);
        tick();
        check("alu_x0_we", {31'd0, wb_we}, 32'd0);
        check("alu_x0_hold_rd", {27'd0, wb_rd}, 32'd5);

        // Single load to r7 with no ALU traffic
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h00001234);
        expect_wr(5'd7, 32'h00001234);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
`ifdef WB_LOAD_BYPASS_EN
        check("ld_byp_we", {31'd0, wb_we}, 32'd1);
        check("ld_byp_rd", {27'd0, wb_rd}, 32'd7);
        check("ld_byp_count", {29'd0, fifo_count}, 32'd0);
        tick();
        check("ld_byp_after_we", {31'd0, wb_we}, 32'd0);
`else
        check("ld_edge1_we", {31'd0, wb_we}, 32'd0);
        check("ld_edge1_count", {29'd0, fifo_count}, 32'd1);
        tick();
        check("ld_edge2_we", {31'd0, wb_we}, 32'd1);
        check("ld_edge2_rd", {27'd0, wb_rd}, 32'd7);
        check("ld_edge2_data", wb_data, 32'h00001234);
        check("ld_edge2_count", {29'd0, fifo_count}, 32'd0);
`endif

        // ALU starvation: loads to r2..r6 offered while ALU writes r1 every cycle
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 5'd1, 32'h100 + k, 1'b1, 5'(2 + k), 32'h200 + k);
            check("starve_ready", {31'd0, mem_ready}, (k < 4) ? 32'd1 : 32'd0);
            expect_wr(5'd1, 32'h100 + k);
            tick();
        end
        check("starve_count", {29'd0, fifo_count}, 32'd4);
        check("starve_ready_full", {31'd0, mem_ready}, 32'd0);
        for (int k = 0; k < 5; k++) expect_wr(5'(2 + k), 32'h200 + k);
        // ALU drops; r6 still offered and taken once a slot frees
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd6, 32'h204);
        tick();
        check("drain0_rd", {27'd0, wb_rd}, 32'd2);
        check("drain0_we", {31'd0, wb_we}, 32'd1);
        check("drain0_count", {29'd0, fifo_count}, 32'd3);
        check("drain0_ready", {31'd0, mem_ready}, 32'd1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("drain1_rd", {27'd0, wb_rd}, 32'd3);
        check("drain1_count", {29'd0, fifo_count}, 32'd3);
        tick();
        check("drain2_rd", {27'd0, wb_rd}, 32'd4);
        tick();
        check("drain3_rd", {27'd0, wb_rd}, 32'd5);
        tick();
        check("drain4_rd", {27'd0, wb_rd}, 32'd6);
        check("drain4_count", {29'd0, fifo_count}, 32'd0);
        tick();
        check("drain_done_we", {31'd0, wb_we}, 32'd0);

        // Squash: buffered load to r9 overtaken by ALU write to r9
        drive(1'b1, 5'd1, 32'h300, 1'b1, 5'd9, 32'h0000AAAA);
        expect_wr(5'd1, 32'h300);
        tick();
        drive(1'b1, 5'd9, 32'h0000BBBB, 1'b0, 5'd0, 32'd0);
        expect_wr(5'd9, 32'h0000BBBB);
        tick();
        check("sq_alu_data", wb_data, 32'h0000BBBB);
        check("sq_count", {29'd0, fifo_count}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check("sq_drain_we", {31'd0, wb_we}, 32'd0);
        check("sq_drain_count", {29'd0, fifo_count}, 32'd0);

        // Same-cycle ALU and load to r3: only the ALU value lands
        drive(1'b1, 5'd3, 32'h333, 1'b1, 5'd3, 32'h444);
        expect_wr(5'd3, 32'h333);
        tick();
        check("same_count", {29'd0, fifo_count}, 32'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        check("same_drain_we", {31'd0, wb_we}, 32'd0);
        check("same_drain_count", {29'd0, fifo_count}, 32'd0);

        // Load to x0 is accepted and discarded
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h999);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("x0_ld_we", {31'd0, wb_we}, 32'd0);
        check("x0_ld_count", {29'd0, fifo_count}, 32'd0);
        tick();
        check("x0_ld_after_we", {31'd0, wb_we}, 32'd0);

        // Mid-stream reset with three buffered loads
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 5'd1, 32'h400 + k, 1'b1, 5'(10 + k), 32'h500 + k);
            expect_wr(5'd1, 32'h400 + k);
            tick();
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        check("prerst_count", {29'd0, fifo_count}, 32'd3);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("midrst_count", {29'd0, fifo_count}, 32'd0);
        check("midrst_we", {31'd0, wb_we}, 32'd0);
        check("midrst_ready", {31'd0, mem_ready}, 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("postrst_we", {31'd0, wb_we}, 32'd0);
        end

        @(negedge clk);
        #1;
        check("sb_leftover", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
